// File: rtl/ssd_driver_unit.sv
// Signed 32-bit value to eight-digit seven-segment display driver.
// Conversion is an iterative double-dabble, one bit per cycle; the display only changes on completion.
module ssd_driver_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DIGITS     = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   IDATA,
    output logic [7*DIGITS-1:0]     HEX,
    output logic                    BUSY,
    output logic                    OVF
);

    // Enough BCD digits to hold the largest magnitude (2^DATA_WIDTH - 1).
    localparam int BCD_DIGITS = (DATA_WIDTH * 301) / 1000 + 1;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = $clog2(DATA_WIDTH + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [1:0] {
        S_RESET,
        S_IDLE,
        S_CONV,
        S_UPDATE
    } state_t;

    state_t                  state_q,  state_d;
    logic [DATA_WIDTH-1:0]   last_q,   last_d;
    logic                    valid_q,  valid_d;
    logic                    sign_q,   sign_d;
    logic [DATA_WIDTH-1:0]   mag_q,    mag_d;
    logic [BCD_W-1:0]        bcd_q,    bcd_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic [7*DIGITS-1:0]     hex_q,    hex_d;
    logic                    ovf_q,    ovf_d;
    logic                    busy_q,   busy_d;

    logic [BCD_W-1:0]        bcd_adj;
    logic [3:0]              disp_nib [DIGITS];
    logic [7*DIGITS-1:0]     hex_num;
    logic [7*DIGITS-1:0]     hex_upd;
    logic                    ovf_calc;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_add3
            assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                        bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
        end
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign disp_nib[gi] = bcd_q[4*gi +: 4];
        end
    endgenerate

    // Scan from the most significant digit down; the first numeral shown gets the sign to its left.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        hex_num = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (disp_nib[i] != 4'd0 || seen || i == 0) begin
                hex_num[7*i +: 7] = seg_of(disp_nib[i]);
                if (!seen && sign_q && i < DIGITS - 1) begin
                    hex_num[7*(i+1) +: 7] = SEG_MINUS;
                end
                seen = 1'b1;
            end
        end
    end

    // A negative value needs one digit for the sign, so it overflows one decade earlier.
    assign ovf_calc = sign_q ? (|bcd_q[BCD_W-1:4*(DIGITS-1)]) : (|bcd_q[BCD_W-1:4*DIGITS]);
    assign hex_upd  = ovf_calc ? {{(DIGITS-1){SEG_BLANK}}, SEG_E} : hex_num;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        valid_d = valid_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (!valid_q || IDATA != last_q) begin
                    last_d  = IDATA;
                    valid_d = 1'b1;
                    sign_d  = IDATA[DATA_WIDTH-1];
                    mag_d   = IDATA[DATA_WIDTH-1] ? (~IDATA + 1'b1) : IDATA;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                hex_d   = hex_upd;
                ovf_d   = ovf_calc;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                hex_d   = '1;
                ovf_d   = 1'b0;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            last_q  <= '0;
            valid_q <= 1'b0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hex_q   <= '1;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    assign HEX  = hex_q;
    assign BUSY = busy_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_ssd_driver_unit.sv
// Scoreboard bench for ssd_driver_unit: expected displays are queued at stimulus time and
// checked by a monitor each time a conversion completes (BUSY falls).
module tb_ssd_driver_unit;

    typedef struct packed {
        logic [55:0] hex;
        logic        ovf;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] IDATA = 32'd0;
    logic [55:0] HEX;
    logic        BUSY;
    logic        OVF;

    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    logic [31:0] last_applied = 32'd0;

    ssd_driver_unit #(.DATA_WIDTH(32), .DIGITS(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .IDATA (IDATA),
        .HEX   (HEX),
        .BUSY  (BUSY),
        .OVF   (OVF)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference: decimal digits by repeated division, then lay them out right-aligned.
    function automatic exp_t model(input logic [31:0] v);
        longint sv, mag;
        int     d[$];
        logic   neg;
        exp_t   e;
        sv    = longint'($signed(v));
        neg   = (sv < 0);
        mag   = neg ? -sv : sv;
        e.ovf = neg ? (mag >= 64'sd10000000) : (mag >= 64'sd100000000);
        e.hex = {56{1'b1}};
        if (e.ovf) begin
            e.hex[6:0] = 7'b0000110;
        end else begin
            do begin
                d.push_back(int'(mag % 10));
                mag = mag / 10;
            end while (mag != 0);
            for (int i = 0; i < 8; i++) begin
                if (i < d.size())
                    e.hex[7*i +: 7] = seg7(d[i]);
                else if (neg && i == d.size())
                    e.hex[7*i +: 7] = 7'b0111111;
            end
        end
        return e;
    endfunction

    // Monitor: BUSY width, display stability during conversion, and result on completion.
    int          busy_cnt  = 0;
    logic        prev_busy = 1'b0;
    logic [55:0] last_hex  = '1;
    always @(negedge CLK) begin
        if (RST) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
            last_hex  = HEX;
        end else begin
            if (BUSY) begin
                busy_cnt++;
                if (prev_busy) begin
                    checks++;
                    if (HEX !== last_hex) begin
                        errors++;
                        $display("FAIL hex_stable: got %h required %h", HEX, last_hex);
                    end
                end
            end else if (prev_busy) begin
                exp_t e;
                checks++;
                if (busy_cnt != 33) begin
                    errors++;
                    $display("FAIL busy_width: got %0d cycles required 33", busy_cnt);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_update: got hex %h with no pending value", HEX);
                end else begin
                    e = exp_q.pop_front();
                    checks += 2;
                    if (HEX !== e.hex) begin
                        errors++;
                        $display("FAIL hex: got %h required %h", HEX, e.hex);
                    end
                    if (OVF !== e.ovf) begin
                        errors++;
                        $display("FAIL ovf: got %b required %b", OVF, e.ovf);
                    end
                end
                done_cnt++;
                $display("txn %0d: hex=%h ovf=%b busy_cycles=%0d", done_cnt, HEX, OVF, busy_cnt);
                busy_cnt = 0;
            end
            prev_busy = BUSY;
            last_hex  = HEX;
        end
    end

    task automatic wait_done(input int n);
        int  target;
        logic hit;
        target = done_cnt + n;
        hit    = 1'b0;
        for (int c = 0; c < 100 * n && !hit; c++) begin
            @(negedge CLK);
            #1;
            if (done_cnt >= target) hit = 1'b1;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL timeout_done: got %0d completions required %0d", done_cnt, target);
        end
    endtask

    task automatic wait_busy();
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge CLK);
            if (BUSY) hit = 1'b1;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL timeout_busy: got BUSY=%b required 1", BUSY);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checks += 3;
        if (HEX !== {56{1'b1}}) begin
            errors++;
            $display("FAIL %s_hex: got %h required all ones", tag, HEX);
        end
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: got %b required 0", tag, BUSY);
        end
        if (OVF !== 1'b0) begin
            errors++;
            $display("FAIL %s_ovf: got %b required 0", tag, OVF);
        end
    endtask

    task automatic apply(input logic [31:0] v);
        exp_q.push_back(model(v));
        last_applied = v;
        @(posedge CLK);
        #1 IDATA = v;
        wait_done(1);
    endtask

    logic [31:0] dir_vals [7];
    initial begin
        logic [31:0] v;
        dir_vals[0] = 32'd1234;
        dir_vals[1] = 32'hFFFFFFFB;
        dir_vals[2] = 32'd99999999;
        dir_vals[3] = 32'd100000000;
        dir_vals[4] = 32'hFF676981;   // -9999999
        dir_vals[5] = 32'hFF676980;   // -10000000
        dir_vals[6] = 32'h80000000;

        // Reset, then zero is converted in the first IDLE cycle.
        repeat (2) @(posedge CLK);
        #1 check_reset_vals("reset");
        exp_q.push_back(model(32'd0));
        RST = 1'b0;
        wait_done(1);

        foreach (dir_vals[i]) apply(dir_vals[i]);

        // Input change while busy: 7 is shown first, then 8 is picked up.
        exp_q.push_back(model(32'd7));
        @(posedge CLK);
        #1 IDATA = 32'd7;
        wait_busy();
        repeat (9) @(posedge CLK);
        #1 IDATA = 32'd8;
        exp_q.push_back(model(32'd8));
        last_applied = 32'd8;
        wait_done(2);

        // Reset on the 20th busy cycle aborts the conversion; the same input is redone after release.
        v = $urandom_range(1, 99999999);
        exp_q.push_back(model(v));
        @(posedge CLK);
        #1 IDATA = v;
        wait_busy();
        repeat (19) @(posedge CLK);
        #1 RST = 1'b1;
        void'(exp_q.pop_back());
        @(posedge CLK);
        #1 check_reset_vals("midreset");
        RST = 1'b0;
        exp_q.push_back(model(v));
        last_applied = v;
        wait_done(1);

        // Randomized values, weighted toward small numbers and the overflow boundaries.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0: v = $urandom;
                1: v = $urandom_range(0, 999);
                2: v = 32'd0 - $urandom_range(1, 9999999);
                3: v = $urandom_range(99999990, 100000009);
                default: v = 32'd0 - $urandom_range(9999990, 10000009);
            endcase
            if (v == last_applied) v = v ^ 32'd1;
            apply(v);
        end

        // An unchanged input must not start another conversion.
        repeat (5) begin
            @(negedge CLK);
            checks++;
            if (BUSY !== 1'b0) begin
                errors++;
                $display("FAIL no_restart: got BUSY=%b required 0", BUSY);
            end
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending: got %0d outstanding required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_driver_unit.md
# ssd_driver_unit

Seven-segment driver that sits directly downstream of the output unit. It takes the 32-bit register value the output unit presents on its seven-segment data port and turns it into eight signed decimal digits on the board's seven-segment displays. Binary-to-BCD conversion is done iteratively (double-dabble, one bit per cycle), so the block needs no wide combinational divider. Display registers only change on a completed conversion, so the segments never show partial results.

## Interface
- DATA_WIDTH, 32, width of the input value; it is treated as two's-complement signed.
- DIGITS, 8, number of seven-segment digits driven.
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  reset, synchronous and active-high.
- IDATA  input  DATA_WIDTH  value to display; it connects to the output unit's SSD port.
- HEX  output  7*DIGITS  segment data, active-low. Bit order per digit is {g,f,e,d,c,b,a}. Digit 0, the rightmost, is HEX[6:0].
- BUSY  output  1  high while a conversion is in progress.
- OVF  output  1  high when the last converted value does not fit on the display.

## Operation
- The FSM has four states: IDLE, CONV, UPDATE and a reset state.
- **IDLE**
  - Compare IDATA with LAST, the value captured for the previous conversion.
  - Start a conversion if the values differ, or if the valid flag is clear (it is cleared by reset).
  - On start:
    - LAST <= IDATA and valid <= 1.
    - sign <= IDATA[31].
    - The shift register gets the magnitude: -IDATA if the value is negative, otherwise IDATA, interpreted as a 32-bit unsigned number. -2^31 gives magnitude 2147483648.
    - The 40-bit BCD register (10 digits) is cleared, the iteration counter is set to 0, and the FSM goes to CONV.
- **CONV** (one iteration per cycle)
  - Every BCD nibble that is >= 5 has 3 added to it.
  - {BCD, magnitude} is then shifted left by 1.
  - After 32 iterations the FSM goes to UPDATE.
- **UPDATE** (one cycle, registers HEX and OVF, then returns to IDLE)
  - OVF is set if either condition holds:
    - the value is non-negative and the magnitude is >= 100000000;
    - the value is negative and the magnitude is >= 10000000.
  - If OVF is set: digit 0 shows 'E' and all other digits are blank.
  - Otherwise:
    - Leading zeros are blanked.
    - Digit 0 always shows a numeral, so a value of 0 displays as "0".
    - For a negative value, a '-' goes in the digit immediately left of the most significant non-zero digit.
- Changes on IDATA while BUSY is high are ignored. They are picked up by the comparison in the next IDLE cycle.
- Segment codes (gfedcba, active-low):

  | Symbol | Code |
  |---|---|
  | 0 | 1000000 |
  | 1 | 1111001 |
  | 2 | 0100100 |
  | 3 | 0110000 |
  | 4 | 0011001 |
  | 5 | 0010010 |
  | 6 | 0000010 |
  | 7 | 1111000 |
  | 8 | 0000000 |
  | 9 | 0010000 |
  | '-' | 0111111 |
  | 'E' | 0000110 |
  | blank | 1111111 |

## Timing
- **Reset values:**
  - HEX = all ones (every digit blank), BUSY = 0, OVF = 0.
  - The valid flag is 0 and the FSM is in IDLE.
- **Reset mid-conversion:** the conversion is aborted and the reset values take effect at the next edge. The first IDLE cycle after reset releases starts a new conversion.
- **Latency**, counting the edge where IDLE samples a changed IDATA as edge 0:
  - Edge 0: BUSY rises.
  - Edges 1 to 32: the 32 conversion iterations.
  - Edge 33: HEX and OVF are updated and BUSY falls.
  - BUSY is therefore high for exactly 33 cycles.
- At least one IDLE cycle separates consecutive conversions.
- HEX and OVF are held stable between UPDATE edges.

## Test plan
1. **Zero after reset:** RST high for 2 cycles, IDATA = 0, then release.
   - A conversion starts in the first IDLE cycle.
   - 33 cycles later: HEX[6:0] = 1000000, all other digits 1111111, OVF = 0.
2. **Positive value and BUSY width:** IDATA = 1234.
   - Digits 3..0 = 1111001, 0100100, 0110000, 0011001 (1, 2, 3, 4); digits 7..4 are blank.
   - BUSY is high for exactly 33 cycles.
3. **Negative value:** IDATA = 32'hFFFFFFFB (-5).
   - Digit 0 = 0010010, digit 1 = 0111111, the rest blank, OVF = 0.
4. **Overflow boundaries:**
   - IDATA = 99999999: all 8 digits = 0010000, OVF = 0.
   - IDATA = 100000000: OVF = 1, digit 0 = 0000110, the rest blank.
   - IDATA = -9999999: digit 7 = '-', digits 6..0 = '9', OVF = 0.
   - IDATA = -10000000: OVF = 1.
   - IDATA = 32'h80000000: OVF = 1.
5. **Input change mid-conversion:** IDATA = 7, then changed to 8 on the 10th BUSY cycle.
   - The first UPDATE shows '7'.
   - A second conversion starts one cycle after the first UPDATE and the final display is '8'.
6. **Reset mid-conversion:** assert RST on the 20th BUSY cycle.
   - Next edge: HEX is all ones, BUSY = 0, OVF = 0.
   - After release, the current IDATA is converted and displayed 34 edges later.
